// File: rtl/serial_add_sub.sv
// Digit-serial adder/subtractor: DIGIT bits per clock through a ripple chain, N = WIDTH/DIGIT cycles.
// Optional signed-overflow output V when SERIAL_ADD_SUB_OVERFLOW_EN is defined.
module serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             mode,
    input  logic             start,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             busy,
    output logic             done
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    ,
    output logic             V
`endif
);

    localparam int N     = WIDTH / DIGIT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   s_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               carry_reg;
    logic               cout_reg;
    logic               busy_reg;
    logic               done_reg;

    logic [DIGIT-1:0]   a_digit;
    logic [DIGIT-1:0]   b_digit;
    logic [DIGIT-1:0]   sum_digit;
    logic               carry_next;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    logic               carry_msb;
    logic               v_reg;
`endif

    assign a_digit = a_reg[idx_reg*DIGIT +: DIGIT];
    assign b_digit = b_reg[idx_reg*DIGIT +: DIGIT];

    // One digit of ripple-carry; the carry into the digit's top bit is kept for overflow.
    always_comb begin
        logic c;
        c         = carry_reg;
        sum_digit = '0;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        carry_msb = carry_reg;
`endif
        for (int i = 0; i < DIGIT; i++) begin
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
            if (i == DIGIT - 1) carry_msb = c;
`endif
            sum_digit[i] = a_digit[i] ^ b_digit[i] ^ c;
            c = (a_digit[i] & b_digit[i]) | (c & (a_digit[i] ^ b_digit[i]));
        end
        carry_next = c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
            v_reg     <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        // Subtract is A + ~B + 1, so the conditioned operand is stored directly.
                        a_reg     <= A;
                        b_reg     <= mode ? ~B : B;
                        carry_reg <= mode ? 1'b1 : Cin;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    s_reg[idx_reg*DIGIT +: DIGIT] <= sum_digit;
                    carry_reg <= carry_next;
                    idx_reg   <= idx_reg + 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg  <= carry_next;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
                        v_reg     <= carry_msb ^ carry_next;
`endif
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign S    = s_reg;
    assign Cout = cout_reg;
    assign busy = busy_reg;
    assign done = done_reg;
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
    assign V    = v_reg;
`endif

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub (WIDTH=16, DIGIT=4) with a result scoreboard.
module tb_serial_add_sub;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] A, B, S;
    logic        Cin, mode, start, Cout, busy, done;
    logic        v;

    int tests    = 0;
    int failures = 0;
    int lat;
    exp_t sb[$];

    always #5 clk = ~clk;

    serial_add_sub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .mode (mode),
        .start(start),
        .S    (S),
        .Cout (Cout),
        .busy (busy),
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        .done (done),
        .V    (v)
`else
        .done (done)
`endif
    );

`ifndef SERIAL_ADD_SUB_OVERFLOW_EN
    assign v = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic m);
        exp_t e;
        logic [15:0] bb;
        logic [16:0] r;
        bb     = m ? ~b : b;
        r      = {1'b0, a} + {1'b0, bb} + {16'd0, (m ? 1'b1 : cin)};
        e.s    = r[15:0];
        e.cout = r[16];
        e.v    = (a[15] == bb[15]) && (r[15] != a[15]);
        return e;
    endfunction

    // Scoreboard consumer: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("S", {16'd0, S}, {16'd0, e.s});
                check("Cout", {31'd0, Cout}, {31'd0, e.cout});
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
                check("V", {31'd0, v}, {31'd0, e.v});
`endif
                $display("[TB] done: S=%h Cout=%b V=%b (exp S=%h Cout=%b V=%b)",
                         S, Cout, v, e.s, e.cout, e.v);
            end
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic m, input exp_t e);
        @(negedge clk);
        A = a; B = b; Cin = cin; mode = m; start = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_run", {31'd0, busy}, 32'd1);
        A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); mode = 1'($urandom);
        wait_done(lat);
        check("latency", lat, 32'd4);
        @(negedge clk);
        check("done_pulse", {31'd0, done}, 32'd0);
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("s_hold", {16'd0, S}, {16'd0, e.s});
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rc, rm;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0; mode = 1'b0;
        #1;
        check("reset_S", {16'd0, S}, 32'd0);
        check("reset_Cout", {31'd0, Cout}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Basic add, wrap-around add, subtract with Cin ignored
        run_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, '{s: 16'h2233, cout: 1'b0, v: 1'b0});
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h0000, cout: 1'b1, v: 1'b0});
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, '{s: 16'hFFFE, cout: 1'b0, v: 1'b0});
`ifdef SERIAL_ADD_SUB_OVERFLOW_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{s: 16'h8000, cout: 1'b0, v: 1'b1});
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, '{s: 16'h7FFF, cout: 1'b1, v: 1'b1});
`endif
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rm = 1'(i % 2);
            run_op(ra, rb, rc, rm, model(ra, rb, rc, rm));
        end

        // start held high through RUN and into DONE is ignored
        @(negedge clk);
        A = 16'h0001; B = 16'h0001; Cin = 1'b0; mode = 1'b0; start = 1'b1;
        sb.push_back('{s: 16'h0002, cout: 1'b0, v: 1'b0});
        repeat (3) begin
            @(negedge clk);
            A = 16'hAAAA;
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("hold_done", {31'd0, done}, 32'd1);
        A = 16'h0003; B = 16'h0004; start = 1'b1;
        sb.push_back('{s: 16'h0007, cout: 1'b0, v: 1'b0});
        @(negedge clk);
        check("done_ignores_start", {31'd0, busy}, 32'd0);
        check("done_single", {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("restart_latency", lat, 32'd4);
        @(negedge clk);

        // Reset mid-operation aborts with no done
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort_S", {16'd0, S}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_Cout", {31'd0, Cout}, 32'd0);
        // start coincident with reset must not be accepted
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("start_in_reset", {31'd0, busy}, 32'd0);
        repeat (6) @(negedge clk);

        run_op(16'h4321, 16'h1234, 1'b1, 1'b1, model(16'h4321, 16'h1234, 1'b1, 1'b1));
        run_op(16'h00FF, 16'h0F01, 1'b1, 1'b0, '{s: 16'h1001, cout: 1'b0, v: 1'b0});

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
